// File: rtl/select_line_scanner.sv
// Serial priority encoder: captures a select-line vector and emits the index of
// every asserted line, lowest first, over a valid/ready handshake.
module select_line_scanner #(
  parameter int LINES = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LINES-1:0] lines_in,
  output logic             busy,
  output logic             idx_valid,
  output logic [IDX_W-1:0] idx_out,
  input  logic             idx_ready,
  output logic             done,
  output logic [IDX_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [LINES-1:0] pending, pending_nxt;
  logic [LINES-1:0] remaining;
  logic [IDX_W-1:0] idx_out_nxt;
  logic             idx_valid_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [IDX_W:0]   count_nxt;

  // Lowest set bit wins; an all-zero vector maps to index 0 but is never emitted.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [LINES-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [LINES-1:0] bit_mask(input logic [IDX_W-1:0] idx);
    logic [LINES-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  assign remaining = pending & ~bit_mask(idx_out);

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    idx_out_nxt   = idx_out;
    idx_valid_nxt = idx_valid;
    count_nxt     = count;
    case (state)
      IDLE: begin
        if (load) begin
          pending_nxt = lines_in;
          count_nxt   = '0;
          if (|lines_in) begin
            state_nxt     = EMIT;
            idx_valid_nxt = 1'b1;
            idx_out_nxt   = lowest_idx(lines_in);
          end else begin
            state_nxt = DONE;
          end
        end
      end
      EMIT: begin
        if (idx_valid && idx_ready) begin
          pending_nxt = remaining;
          count_nxt   = count + (IDX_W + 1)'(1);
          if (|remaining) begin
            idx_out_nxt = lowest_idx(remaining);
          end else begin
            idx_valid_nxt = 1'b0;
            state_nxt     = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt     = IDLE;
        pending_nxt   = '0;
        idx_valid_nxt = 1'b0;
      end
    endcase
    // busy and done are registered, so they are derived from the next state.
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      idx_out   <= '0;
      idx_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      idx_out   <= idx_out_nxt;
      idx_valid <= idx_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      count     <= count_nxt;
    end
  end

endmodule

// File: doc/select_line_scanner.md
Name: select_line_scanner

Overview:
- Reverse direction of the 4-to-16 enable-select decoder.
- Captures a 16-bit set of select lines (for example one board row's occupancy or enable word) and serially encodes every asserted line back into its 4-bit index, lowest index first.
- Each index is delivered over a valid/ready handshake.
- Sits between memory row readout and game logic that consumes cell indices.

Parameters:
- LINES, 16, number of select lines scanned; must be a power of 2.
- IDX_W, 4, index width; equals log2(LINES).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  start request; sampled only in IDLE.
- lines_in  input  LINES  select-line vector captured on an accepted load.
- busy  output  1  high in EMIT and DONE; low in IDLE.
- idx_valid  output  1  idx_out holds a valid index.
- idx_out  output  IDX_W  index of the current lowest pending line.
- idx_ready  input  1  consumer accepts idx_out this cycle.
- done  output  1  one-cycle pulse when a scan completes.
- count  output  IDX_W+1  number of indices emitted in the current or last scan (0..16).

Behaviour:
- Reset (async, immediate, any state):
  - state=IDLE, pending=0, idx_out=0, idx_valid=0, done=0, busy=0, count=0.
- States: IDLE, EMIT, DONE. All outputs are registered.
- IDLE, load=1 at edge N:
  - pending<=lines_in, count<=0.
  - If lines_in!=0: state<=EMIT, idx_valid<=1, idx_out<=index of lowest set bit of lines_in. idx_valid is visible in cycle N+1 (latency 1).
  - If lines_in==0: state<=DONE. No index is emitted.
- EMIT, handshake (idx_valid & idx_ready):
  - Clear bit idx_out in pending; count<=count+1.
  - If the remaining pending is nonzero: idx_out<=lowest remaining set index and idx_valid stays 1. Emission is back-to-back, one index per cycle when idx_ready is held high.
  - If the remaining pending is zero: idx_valid<=0, state<=DONE.
- EMIT, idx_ready=0: idx_out, idx_valid, pending and count hold stable. Stall length is unbounded.
- DONE: done=1 for exactly one cycle, then state<=IDLE.
  - count holds the final value until the next accepted load.
  - pending is 0 in DONE.
- load while busy: ignored. No capture and no state change.
- lines_in is sampled only on an accepted load; later changes do not affect the scan in progress.
- Priority encode is combinational from pending, lowest index wins.
- Indices are emitted strictly ascending. Each set bit is emitted exactly once.
- count never exceeds LINES. The 16-bit all-ones case yields count=16 (5 bits, no wrap).
- Simultaneous load and reset: reset wins.
- Reset mid-EMIT: the scan is aborted with no done pulse. The consumer must discard any partial index stream.

Test Plan:
- Single line: reset, load lines_in=16'h0001, idx_ready=1.
  - Required: idx_valid=1 with idx_out=0 one cycle after load.
  - Next cycle: done=1, count=1.
  - Then busy=0.
- Sparse, no stall: load 16'h8421, idx_ready held 1.
  - Required: idx_out 0, 5, 10, 15 on four consecutive cycles.
  - Then done pulse one cycle, count=4.
- Empty vector: load 16'h0000.
  - Required: idx_valid never asserts.
  - done=1 in the cycle after load, count=0.
- Full vector with backpressure: load 16'hFFFF, idx_ready toggling 1,0,1,0.
  - Required: indices 0..15 in order, each held stable while idx_ready=0.
  - count=16 at done.
- Load while busy: during EMIT of 16'h0003, pulse load with lines_in=16'hF000.
  - Required: output is indices 0, 1 only, count=2.
  - The new vector is not captured.
- Async reset: assert reset mid-scan of 16'h00F0 between clock edges.
  - Required: idx_valid, busy, count and done go 0 immediately, state is IDLE, and no done pulse follows.
  - A subsequent load of 16'h0100 yields idx_out=8.
